// File: rtl/mux2_share_arbiter.sv
// Round-robin owner of a shared 2:1 enabled bus mux: registered grants, bounded
// tenure with preemption, and a one-cycle mux-disabled turnaround between owners.
module mux2_share_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              mux_e,
    output logic              mux_s,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              last, last_nxt;
    logic              gnt0_nxt, gnt1_nxt, mux_e_nxt, mux_s_nxt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              at_lim;

    assign at_lim = (hold_cnt == HOLD_LIM);

    // State, priority flag and all outputs are registered together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            mux_e    <= 1'b0;
            mux_s    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            gnt0     <= gnt0_nxt;
            gnt1     <= gnt1_nxt;
            mux_e    <= mux_e_nxt;
            mux_s    <= mux_s_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next state plus next-cycle output values decoded from it.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        hold_nxt  = '0;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        mux_e_nxt = 1'b0;
        mux_s_nxt = 1'b0;

        unique case (state)
            IDLE, TURN: begin
                // last holds the previous owner, so on a tie the other side wins
                if (req0 && !req1)      state_nxt = OWN0;
                else if (req1 && !req0) state_nxt = OWN1;
                else if (req0 && req1)  state_nxt = last ? OWN0 : OWN1;
                else                    state_nxt = IDLE;
                if (state_nxt != IDLE) hold_nxt = HOLD_ONE;
            end
            OWN0: begin
                if (!req0 || (at_lim && req1)) begin
                    state_nxt = TURN;
                    last_nxt  = 1'b0;
                end else begin
                    hold_nxt = at_lim ? hold_cnt : hold_cnt + HOLD_ONE;
                end
            end
            OWN1: begin
                if (!req1 || (at_lim && req0)) begin
                    state_nxt = TURN;
                    last_nxt  = 1'b1;
                end else begin
                    hold_nxt = at_lim ? hold_cnt : hold_cnt + HOLD_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        gnt0_nxt  = (state_nxt == OWN0);
        gnt1_nxt  = (state_nxt == OWN1);
        mux_e_nxt = gnt0_nxt | gnt1_nxt;
        mux_s_nxt = gnt0_nxt;
    end

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// Directed self-checking bench for mux2_share_arbiter (MAX_HOLD=8, HOLD_W=4).
module tb_mux2_share_arbiter;

    logic       clk;
    logic       clk_en;
    logic       reset_n;
    logic       req0, req1;
    logic       gnt0, gnt1, mux_e, mux_s;
    logic [3:0] hold_cnt;
    logic [7:0] obs;
    int         tests;
    int         fails;

    mux2_share_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .req1     (req1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .mux_e    (mux_e),
        .mux_s    (mux_s),
        .hold_cnt (hold_cnt)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    assign obs = {gnt0, gnt1, mux_e, mux_s, hold_cnt};

    // Expected {gnt0, gnt1, mux_e, mux_s, hold_cnt} for a given owner and count.
    function automatic logic [7:0] expv(input logic g0, input logic g1, input int h);
        return {g0, g1, g0 | g1, g0, 4'(h)};
    endfunction

    task automatic test_reset();
        logic [7:0] e;
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        e = expv(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_idle got=%h exp=%h", obs, e); end
        req0 = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_held got=%h exp=%h", obs, e); end
        reset_n = 1'b1;
        @(negedge clk);
        e = expv(1, 0, 1);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_first_gnt got=%h exp=%h", obs, e); end
        @(negedge clk);
        e = expv(1, 0, 2);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_own0_h2 got=%h exp=%h", obs, e); end
        // Async reset with the clock stopped mid-tenure
        clk_en = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        e = expv(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_async got=%h exp=%h", obs, e); end
        req1 = 1'b1;
        #2 reset_n = 1'b1;
        #2 clk_en = 1'b1;
        @(negedge clk);
        e = expv(1, 0, 1);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_tie_gnt0 got=%h exp=%h", obs, e); end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        e = expv(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_turn got=%h exp=%h", obs, e); end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] e;
        req1 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            e = expv(0, 1, i);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL single_own1 cyc=%0d got=%h exp=%h", i, obs, e); end
        end
        req1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = expv(0, 0, 0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL single_after cyc=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_contention();
        logic [7:0] e;
        req0 = 1'b1; req1 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                e = (r % 2 == 0) ? expv(1, 0, i) : expv(0, 1, i);
                tests++;
                if (obs !== e) begin fails++; $display("FAIL contend r=%0d cyc=%0d got=%h exp=%h", r, i, obs, e); end
            end
            @(negedge clk);
            e = expv(0, 0, 0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL contend_turn r=%0d got=%h exp=%h", r, obs, e); end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        e = expv(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL contend_idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_no_preempt();
        logic [7:0] e;
        req0 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            e = expv(1, 0, (i > 8) ? 8 : i);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL nopreempt cyc=%0d got=%h exp=%h", i, obs, e); end
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        e = expv(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL nopreempt_idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_tie_after_release();
        logic [7:0] e;
        req1 = 1'b1;
        repeat (3) @(negedge clk);
        e = expv(0, 1, 3);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL tie_own1 got=%h exp=%h", obs, e); end
        req1 = 1'b0;
        @(negedge clk);
        e = expv(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL tie_turn got=%h exp=%h", obs, e); end
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        e = expv(1, 0, 1);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL tie_winner got=%h exp=%h", obs, e); end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        e = expv(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL tie_idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_simul_release();
        logic [7:0] e;
        // last is 0 here, so requester 1 takes the tie
        req0 = 1'b1; req1 = 1'b1;
        repeat (8) @(negedge clk);
        e = expv(0, 1, 8);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL simul_own1_lim got=%h exp=%h", obs, e); end
        req1 = 1'b0;
        @(negedge clk);
        e = expv(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL simul_turn got=%h exp=%h", obs, e); end
        @(negedge clk);
        e = expv(1, 0, 1);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL simul_other got=%h exp=%h", obs, e); end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        e = expv(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL simul_idle got=%h exp=%h", obs, e); end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        clk     = 1'b0;
        clk_en  = 1'b1;
        reset_n = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_no_preempt();
        test_tie_after_release();
        test_simul_release();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux2_share_arbiter.md
# mux2_share_arbiter

Round-robin arbiter that shares one 2-to-1 enabled mux (the 16-bit bus mux built from 1-bit mux slices) between two requesters in the CPU datapath. It sequences ownership with registered grants, bounds each tenure by a hold limit, and inserts a one-cycle turnaround with the mux disabled between owners. It drives the mux `E` and `S` inputs directly and returns per-requester grants.

## Interface
- `MAX_HOLD`, 8: max consecutive owned cycles before preemption when the other side requests; legal 1..(2^HOLD_W − 1)
- `HOLD_W`, 4: width of hold counter and `hold_cnt` output

- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `req0` in 1: requester 0 wants the mux; held high for the whole tenure
- `req1` in 1: requester 1 wants the mux
- `gnt0` out 1: requester 0 owns the mux
- `gnt1` out 1: requester 1 owns the mux
- `mux_e` out 1: mux enable; high only while an owner exists
- `mux_s` out 1: mux select; 1 routes requester 0 (X0), 0 routes requester 1 (X1)
- `hold_cnt` out HOLD_W: cycles owned in current tenure, 0 when no owner

## Operation
- States: IDLE, OWN0, OWN1, TURN. Priority flag `last` records the most recent owner.
- Arbitration (from IDLE or TURN): only one of req0/req1 high → that side wins; both high → side ≠ `last` wins; none → IDLE.
- OWNx: gntx=1, mux_e=1, mux_s=1 for OWN0, 0 for OWN1; other gnt=0.
- hold_cnt = 1 in the first OWN cycle, +1 per cycle, saturates at MAX_HOLD.
- Leave OWNx → TURN when reqx sampled low (release), or when hold_cnt==MAX_HOLD and the other req is sampled high (preempt). On leaving, `last` := x.
- hold_cnt==MAX_HOLD with other side idle: stay in OWNx, no preemption, counter saturated.
- TURN: lasts exactly 1 cycle. gnt0=gnt1=0, mux_e=0, mux_s=0, hold_cnt=0. Then arbitrate as above.
- Any state other than OWNx: mux_e=0, mux_s=0, gnts 0, hold_cnt=0.
- gnt0 and gnt1 are never high together. mux_e == gnt0|gnt1 on every cycle.

## Timing
- All outputs registered, updated at rising edge of clk.
- Reset (reset_n low, async): state IDLE, last=1 (requester 0 wins first tie), all outputs 0 immediately, no clock needed. Reset during a tenure drops the grant at once. First arbitration happens on the first clk edge after reset_n is high.
- Grant latency from IDLE: req sampled high at edge N → gnt high after edge N (one cycle).
- Release latency: reqx sampled low at edge N → gntx low after edge N. The next grant is high after edge N+1 at the earliest (TURN in between).
- Preempt: hold_cnt==MAX_HOLD with other req high at edge N → TURN after N, other side owns after N+1. A tenure lasts at most MAX_HOLD cycles under contention.
- Owner deasserts req on the same edge it would be preempted: treated as a release (same result, TURN).
- MAX_HOLD=1 under constant contention: ownership alternates 1 cycle owned, 1 cycle TURN.

## Test plan
- Reset: hold reset_n low mid-OWN0 with clk stopped → gnt0, mux_e, mux_s, hold_cnt go to 0 asynchronously. Release reset with both req high → gnt0 at first edge, mux_s=1.
- Single requester: req1 high for 5 cycles then low → gnt1 for 5 cycles, mux_s=0, mux_e=1, hold_cnt 1..5 (clamping at MAX_HOLD not reached). Then TURN, then IDLE.
- Contention, MAX_HOLD=8: req0 and req1 held high → gnt0 for 8 cycles, 1 idle cycle, gnt1 for 8 cycles, repeating. gnt0 and gnt1 never overlap.
- No preemption: req0 only, held for 20 cycles → gnt0 continuous 20 cycles, hold_cnt saturates at 8.
- Tie after release: OWN1 releases, both req high in TURN → requester 0 wins (last=1).
- Simultaneous release and preempt at hold_cnt==MAX_HOLD → one TURN cycle, then the other side is granted.
